// File: rtl/mult_dispatch_if.sv
// rtl/mult_dispatch_if.sv - handshake and multiplier bus bundle for mult_dispatch
//
// Groups three sets of signals:
//   operand input stream  : in_valid, in_ready, in_a, in_b
//   multiplier link       : mul_start, mul_M, mul_Q, mul_done, mul_result
//   product output stream : out_valid, out_ready, out_result
// slave  : the dispatcher's side of the bundle.
// master : the environment's side (producer, multiplier and consumer).

interface mult_dispatch_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;

    logic        mul_start;
    logic [31:0] mul_M;
    logic [31:0] mul_Q;
    logic        mul_done;
    logic [63:0] mul_result;

    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;

    modport slave (
        input  in_valid, in_a, in_b, mul_done, mul_result, out_ready,
        output in_ready, mul_start, mul_M, mul_Q, out_valid, out_result
    );

    modport master (
        output in_valid, in_a, in_b, mul_done, mul_result, out_ready,
        input  in_ready, mul_start, mul_M, mul_Q, out_valid, out_result
    );
endinterface

// File: rtl/mult_dispatch.sv
// rtl/mult_dispatch.sv - operand FIFO feeding a sequential multiplier, with timeout
//
// Ports:
//   clk    : single clock, rising edge
//   rst    : synchronous active-low reset
//   bus    : mult_dispatch_if.slave (operand stream in, multiplier link,
//            product stream out)
//   err    : sticky timeout flag, cleared only by reset
//   count  : operand FIFO occupancy, 0..DEPTH
//
// Operand pairs are queued in a DEPTH-entry FIFO. One pair at a time is
// handed to the multiplier; the product (or 0 on timeout) is held in a
// single output slot until the consumer takes it. A new pair is only
// dispatched when the output slot is free or being drained, so results
// leave in push order.

module mult_dispatch #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    mult_dispatch_if.slave         bus,
    output logic                   err,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        START,
        SETTLE,
        WAIT
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          mul_start_q, mul_start_d;
    logic [31:0]   mul_m_q, mul_m_d;
    logic [31:0]   mul_q_q, mul_q_d;
    logic          out_valid_q, out_valid_d;
    logic [63:0]   out_result_q, out_result_d;
    logic          err_q, err_d;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;

    logic [63:0]   mem_q [DEPTH];

    logic          in_ready;
    logic          push;
    logic          go;

    // in_ready is gated by rst so nothing is accepted while reset is held.
    assign in_ready = rst && (count_q < DEPTH_C);
    assign push     = bus.in_valid && in_ready;

    // Dispatch needs a queued pair and an output slot that is empty or being
    // emptied this cycle, so a finished product never has to wait for room.
    assign go = (state_q == IDLE) && (count_q != '0) &&
                (!out_valid_q || bus.out_ready);

    // Pair storage carries no reset: entries are only read behind count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.in_a, bus.in_b};
        end
    end

    // FIFO pointers and occupancy. The pop coincides with the IDLE->START
    // edge so the head lands in mul_M/mul_Q in the same cycle mul_start is
    // high. Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (go) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, go})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Dispatch FSM and output slot.
    always_comb begin
        state_d      = state_q;
        mul_start_d  = 1'b0;
        mul_m_d      = mul_m_q;
        mul_q_d      = mul_q_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        err_d        = err_q;
        wait_cnt_d   = wait_cnt_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (go) begin
                    state_d            = START;
                    mul_start_d        = 1'b1;
                    {mul_m_d, mul_q_d} = mem_q[rd_ptr_q];
                end
            end
            START: begin
                state_d = SETTLE;
            end
            SETTLE: begin
                // mul_done may still be high from the previous product, so
                // it is not looked at until the multiplier has seen start.
                state_d    = WAIT;
                wait_cnt_d = '0;
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (bus.mul_done) begin
                    out_result_d = bus.mul_result;
                    out_valid_d  = 1'b1;
                    state_d      = IDLE;
                end else if (wait_cnt_d == TIMEOUT_C) begin
                    // Emitting a 0 result for the aborted pair keeps later results in order.
                    err_d        = 1'b1;
                    out_result_d = '0;
                    out_valid_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            mul_start_q  <= 1'b0;
            mul_m_q      <= '0;
            mul_q_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            err_q        <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            mul_start_q  <= mul_start_d;
            mul_m_q      <= mul_m_d;
            mul_q_q      <= mul_q_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            err_q        <= err_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.mul_start  = mul_start_q;
    assign bus.mul_M      = mul_m_q;
    assign bus.mul_Q      = mul_q_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign err            = err_q;
    assign count          = count_q;

endmodule
